// File: rtl/hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_ctrl: load-use, branch and memory-hold pipeline control    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [31:0]      instr_id,
  input  logic             ex_mem_to_reg,
  input  logic [4:0]       ex_rt,
  input  logic             mem_busy,
  input  logic             br_resolved,
  output logic             pc_ena,
  output logic             ifid_ena,
  output logic             flush_ifid,
  output logic             stop,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_BR_WAIT = 2'b01,
    ST_HOLD    = 2'b10,
    ST_BAD     = 2'b11
  } state_t;

  localparam logic [5:0]       C_OP_BEQ  = 6'b000100;
  localparam logic [5:0]       C_OP_BNE  = 6'b000101;
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  state_t           r_ret;
  state_t           w_ret_nxt;
  logic             r_pend;
  logic             w_pend_nxt;
  logic [CNT_W-1:0] r_cnt;

  logic w_load_use;
  logic w_branch;
  logic w_pc_ena;
  logic w_ifid_ena;
  logic w_flush;
  logic w_stop;
  logic w_unused;

  assign w_load_use = ex_mem_to_reg && (ex_rt != 5'd0) &&
                      ((ex_rt == instr_id[25:21]) || (ex_rt == instr_id[20:16]));
  assign w_branch   = (instr_id[31:26] == C_OP_BEQ) || (instr_id[31:26] == C_OP_BNE);

  // Immediate and offset fields play no part in hazard detection.
  assign w_unused = ^instr_id[15:0];

  always_comb begin
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret;
    w_pend_nxt  = r_pend;
    w_pc_ena    = 1'b0;
    w_ifid_ena  = 1'b0;
    w_flush     = 1'b0;
    w_stop      = 1'b0;
    if (!rst) begin
      w_stop = 1'b1;
    end else if (ena) begin
      case (r_state)
        ST_RUN: begin
          if (mem_busy) begin
            w_state_nxt = ST_HOLD;
            w_ret_nxt   = ST_RUN;
          end else if (w_load_use) begin
            w_stop = 1'b1;
          end else if (w_branch) begin
            w_ifid_ena  = 1'b1;
            w_flush     = 1'b1;
            w_state_nxt = ST_BR_WAIT;
          end else begin
            w_pc_ena   = 1'b1;
            w_ifid_ena = 1'b1;
          end
        end
        ST_BR_WAIT: begin
          if (mem_busy) begin
            w_state_nxt = ST_HOLD;
            w_ret_nxt   = ST_BR_WAIT;
            // A resolution coinciding with the hold must not be lost.
            if (br_resolved) begin
              w_pend_nxt = 1'b1;
            end
          end else begin
            w_ifid_ena = 1'b1;
            w_flush    = 1'b1;
            w_stop     = 1'b1;
            if (br_resolved || r_pend) begin
              w_pc_ena    = 1'b1;
              w_pend_nxt  = 1'b0;
              w_state_nxt = ST_RUN;
            end
          end
        end
        ST_HOLD: begin
          if (br_resolved && (r_ret == ST_BR_WAIT)) begin
            w_pend_nxt = 1'b1;
          end
          if (!mem_busy) begin
            w_state_nxt = r_ret;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_pend_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
      r_ret   <= ST_RUN;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ret   <= w_ret_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  // w_stop is already zero whenever ena is low, so no separate ena term.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_stop && (r_cnt != C_CNT_MAX)) begin
      r_cnt <= r_cnt + C_CNT_ONE;
    end
  end

  assign pc_ena     = w_pc_ena;
  assign ifid_ena   = w_ifid_ena;
  assign flush_ifid = w_flush;
  assign stop       = w_stop;
  assign state      = r_state;
  assign stall_cnt  = r_cnt;

endmodule

`default_nettype wire
